mult_wb_unit: RTL and testbench

MULT_WB_UNIT -- requirements
Module: mult_wb_unit

---
 rtl/mult_wb_unit_pkg.sv | 15 +
 rtl/mult_wb_unit_if.sv | 29 ++
 rtl/mult_shift_add_dp.sv | 61 ++++++
 rtl/mult_wb_unit.sv | 134 +++++++++++++
 tb/tb_mult_wb_unit.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_wb_unit_pkg.sv
// Shared definitions for the iterative multiplier and its register-bank write port.
// The high result word always lands in EXT_REG alongside the addressed low word.
package mult_wb_unit_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int EXT_REG    = 19;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } state_t;

endpackage

// File: rtl/mult_wb_unit_if.sv
// Core-facing request/write-back bundle of the multiplier.
// The core drives the request side (master); the unit drives busy and the write port (slave).
interface mult_wb_unit_if #(
   parameter int XLEN = mult_wb_unit_pkg::XLEN
);
   import mult_wb_unit_pkg::REG_ADDR_W;

   logic                  start;
   logic                  signed_op;
   logic [XLEN-1:0]       opA;
   logic [XLEN-1:0]       opB;
   logic [REG_ADDR_W-1:0] dstAddr;
   logic                  busy;
   logic                  RegWrite;
   logic [REG_ADDR_W-1:0] wrAddr;
   logic [XLEN-1:0]       wrData;
   logic [XLEN-1:0]       wrDataExt;

   modport master (
      output start, signed_op, opA, opB, dstAddr,
      input  busy, RegWrite, wrAddr, wrData, wrDataExt
   );

   modport slave (
      input  start, signed_op, opA, opB, dstAddr,
      output busy, RegWrite, wrAddr, wrData, wrDataExt
   );

endinterface

// File: rtl/mult_shift_add_dp.sv
// Radix-2 shift-add datapath: operand magnitudes, running product and iteration counter.
// o_prod_nxt is the product including the current step, so the final step's sum is visible on the last edge.
module mult_shift_add_dp #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_signed,
   input  logic [XLEN-1:0]   i_op_a,
   input  logic [XLEN-1:0]   i_op_b,
   output logic              o_last,
   output logic              o_neg,
   output logic [2*XLEN-1:0] o_prod_nxt
);

   logic [2*XLEN-1:0] r_prod;
   logic [2*XLEN-1:0] r_mcand;
   logic [XLEN-1:0]   r_mplier;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_neg;

   logic              w_neg_a;
   logic              w_neg_b;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;

   // The most negative operand negates to itself, which read as unsigned is the correct magnitude.
   assign w_neg_a = i_signed & i_op_a[XLEN-1];
   assign w_neg_b = i_signed & i_op_b[XLEN-1];
   assign w_mag_a = w_neg_a ? -i_op_a : i_op_a;
   assign w_mag_b = w_neg_b ? -i_op_b : i_op_b;

   assign o_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
   assign o_last     = (r_cnt == CNT_W'(XLEN - 1));
   assign o_neg      = r_neg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
      end else if (i_load) begin
         r_prod   <= '0;
         r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
         r_mplier <= w_mag_b;
         r_cnt    <= '0;
         r_neg    <= w_neg_a ^ w_neg_b;
      end else if (i_step) begin
         r_prod   <= o_prod_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mult_wb_unit.sv
// Iterative XLEN x XLEN multiplier writing the low word to dstAddr and the high word to the extension register.
// 32 cycles from start to the write strobe (0 when either operand is zero); busy stalls the core meanwhile.
module mult_wb_unit #(
   parameter int XLEN  = mult_wb_unit_pkg::XLEN,
   parameter int CNT_W = 6
) (
   input  logic          clk,
   input  logic          reset,
   mult_wb_unit_if.slave bus
);
   import mult_wb_unit_pkg::state_t;
   import mult_wb_unit_pkg::IDLE;
   import mult_wb_unit_pkg::CALC;
   import mult_wb_unit_pkg::WB;
   import mult_wb_unit_pkg::REG_ADDR_W;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [REG_ADDR_W-1:0] r_dst;

   logic                  r_regwrite;
   logic [REG_ADDR_W-1:0] r_wr_addr;
   logic [XLEN-1:0]       r_wr_lo;
   logic [XLEN-1:0]       r_wr_hi;

   logic                  w_load;
   logic                  w_step;
   logic                  w_last;
   logic                  w_neg;
   logic                  w_zero;
   logic                  w_wr_upd;
   logic                  w_wr_en;
   logic [REG_ADDR_W-1:0] w_wr_addr;
   logic [2*XLEN-1:0]     w_prod_nxt;
   logic [2*XLEN-1:0]     w_res;
   logic [2*XLEN-1:0]     w_wr_val;

   mult_shift_add_dp #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_step     (w_step),
      .i_signed   (bus.signed_op),
      .i_op_a     (bus.opA),
      .i_op_b     (bus.opB),
      .o_last     (w_last),
      .o_neg      (w_neg),
      .o_prod_nxt (w_prod_nxt)
   );

   assign w_zero  = (bus.opA == '0) || (bus.opB == '0);
   assign w_res   = w_neg ? -w_prod_nxt : w_prod_nxt;
   // Register 0 is hardwired, so a write there is dropped but the timing is kept.
   assign w_wr_en = w_wr_upd && (w_wr_addr != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_wr_upd    = 1'b0;
      w_wr_val    = '0;
      w_wr_addr   = r_dst;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_load    = 1'b1;
               w_wr_addr = bus.dstAddr;
               if (w_zero) begin
                  w_state_nxt = WB;
                  w_wr_upd    = 1'b1;
               end else begin
                  w_state_nxt = CALC;
               end
            end
         end
         CALC: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = WB;
               w_wr_upd    = 1'b1;
               w_wr_val    = w_res;
            end
         end
         WB: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dst <= '0;
      end else if (w_load) begin
         r_dst <= bus.dstAddr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_regwrite <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_lo    <= '0;
         r_wr_hi    <= '0;
      end else begin
         r_regwrite <= w_wr_en;
         if (w_wr_en) begin
            r_wr_addr <= w_wr_addr;
            r_wr_lo   <= w_wr_val[XLEN-1:0];
            r_wr_hi   <= w_wr_val[2*XLEN-1:XLEN];
         end
      end
   end

   assign bus.busy      = (r_state != IDLE);
   assign bus.RegWrite  = r_regwrite;
   assign bus.wrAddr    = r_wr_addr;
   assign bus.wrData    = r_wr_lo;
   assign bus.wrDataExt = r_wr_hi;

endmodule

// File: tb/tb_mult_wb_unit.sv
// Self-checking bench for mult_wb_unit: directed corner cases plus randomized operations
// compared against an arithmetic reference of the write-back behaviour.
module tb_mult_wb_unit;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mult_wb_unit_if #(.XLEN(32)) bus ();

   mult_wb_unit #(
      .XLEN  (32),
      .CNT_W (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Observations of one run: cycle index (0 = cycle right after the start edge) of each strobe.
   int          obs_busy;
   int          obs_cyc[$];
   logic [4:0]  obs_addr[$];
   logic [31:0] obs_lo[$];
   logic [31:0] obs_hi[$];

   // Reference view of the write-port registers as the bank would see them.
   logic [4:0]  m_addr;
   logic [31:0] m_lo;
   logic [31:0] m_hi;

   task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [4:0] dst, output int lat, output int pulses,
                           output int busy_n, output logic [63:0] res);
      longint sa;
      longint sb;
      bit     zero;
      zero = (a == 32'h0) || (b == 32'h0);
      if (zero) begin
         res = 64'h0;
      end else if (sgn) begin
         sa  = longint'($signed(a));
         sb  = longint'($signed(b));
         res = 64'(sa * sb);
      end else begin
         res = {32'h0, a} * {32'h0, b};
      end
      lat    = zero ? 0 : 32;
      busy_n = zero ? 1 : 33;
      pulses = (dst != 5'd0) ? 1 : 0;
      if (dst != 5'd0) begin
         m_addr = dst;
         m_lo   = res[31:0];
         m_hi   = res[63:32];
      end
   endtask

   task automatic first_pulse(input int idx, output int lat, output logic [4:0] addr,
                              output logic [31:0] lo, output logic [31:0] hi);
      if (obs_cyc.size() > idx) begin
         lat  = obs_cyc[idx];
         addr = obs_addr[idx];
         lo   = obs_lo[idx];
         hi   = obs_hi[idx];
      end else begin
         lat  = -1;
         addr = 'x;
         lo   = 'x;
         hi   = 'x;
      end
   endtask

   // Called at a falling edge: presents a start, then watches `window` cycles while scrambling
   // the operands; optionally presents a second start on edge `restart_at`.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [4:0] dst, input int window, input int restart_at,
                         input logic [31:0] a2, input logic [31:0] b2, input logic sgn2,
                         input logic [4:0] dst2);
      obs_busy = 0;
      obs_cyc.delete();
      obs_addr.delete();
      obs_lo.delete();
      obs_hi.delete();
      bus.start     = 1'b1;
      bus.opA       = a;
      bus.opB       = b;
      bus.signed_op = sgn;
      bus.dstAddr   = dst;
      @(posedge clk);
      for (int k = 0; k < window; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) obs_busy++;
         if (bus.RegWrite === 1'b1) begin
            obs_cyc.push_back(k);
            obs_addr.push_back(bus.wrAddr);
            obs_lo.push_back(bus.wrData);
            obs_hi.push_back(bus.wrDataExt);
         end
         if (k + 1 == restart_at) begin
            bus.start     = 1'b1;
            bus.opA       = a2;
            bus.opB       = b2;
            bus.signed_op = sgn2;
            bus.dstAddr   = dst2;
         end else begin
            bus.start     = 1'b0;
            bus.opA       = $urandom;
            bus.opB       = $urandom;
            bus.signed_op = 1'($urandom_range(0, 1));
            bus.dstAddr   = 5'($urandom_range(0, 31));
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      int          e_lat, e_pulses, e_busy, lat;
      logic [63:0] res;
      logic [4:0]  addr;
      logic [31:0] lo, hi;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
      n_checks++; if (bus.RegWrite !== 1'b0) $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite); else n_pass++;
      n_checks++; if (bus.wrAddr !== 5'd0) $display("FAIL reset_wraddr: got %0d want 0", bus.wrAddr); else n_pass++;
      n_checks++; if (bus.wrData !== 32'h0) $display("FAIL reset_wrdata: got %h want 0", bus.wrData); else n_pass++;
      n_checks++; if (bus.wrDataExt !== 32'h0) $display("FAIL reset_wrdataext: got %h want 0", bus.wrDataExt); else n_pass++;
      m_addr = 5'd0;
      m_lo   = 32'h0;
      m_hi   = 32'h0;
      // Start presented on the very first edge after release; 3*5 into r8.
      reset = 1'b0;
      model_op(32'd3, 32'd5, 1'b0, 5'd8, e_lat, e_pulses, e_busy, res);
      run_op(32'd3, 32'd5, 1'b0, 5'd8, 40, -1, 32'h0, 32'h0, 1'b0, 5'd0);
      first_pulse(0, lat, addr, lo, hi);
      n_checks++; if (obs_cyc.size() != e_pulses) $display("FAIL first_op_pulses: got %0d want %0d", obs_cyc.size(), e_pulses); else n_pass++;
      n_checks++; if (lat != e_lat) $display("FAIL first_op_latency: got %0d want %0d", lat, e_lat); else n_pass++;
      n_checks++; if (addr !== 5'd8) $display("FAIL first_op_addr: got %0d want 8", addr); else n_pass++;
      n_checks++; if (lo !== res[31:0]) $display("FAIL first_op_lo: got %h want %h", lo, res[31:0]); else n_pass++;
      n_checks++; if (hi !== res[63:32]) $display("FAIL first_op_hi: got %h want %h", hi, res[63:32]); else n_pass++;
      n_checks++; if (obs_busy != e_busy) $display("FAIL first_op_busy: got %0d want %0d", obs_busy, e_busy); else n_pass++;
   endtask

   task automatic test_directed();
      logic [31:0] ta[6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] tb[6] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
      logic        ts[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [4:0]  td[6] = '{5'd12, 5'd3, 5'd19, 5'd31, 5'd7, 5'd1};
      int          e_lat, e_pulses, e_busy, lat;
      logic [63:0] res;
      logic [4:0]  addr;
      logic [31:0] lo, hi;
      for (int i = 0; i < 6; i++) begin
         model_op(ta[i], tb[i], ts[i], td[i], e_lat, e_pulses, e_busy, res);
         run_op(ta[i], tb[i], ts[i], td[i], 40, -1, 32'h0, 32'h0, 1'b0, 5'd0);
         first_pulse(0, lat, addr, lo, hi);
         n_checks++; if (obs_cyc.size() != e_pulses) $display("FAIL directed%0d_pulses: got %0d want %0d", i, obs_cyc.size(), e_pulses); else n_pass++;
         n_checks++; if (lat != e_lat) $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, e_lat); else n_pass++;
         n_checks++; if (addr !== td[i]) $display("FAIL directed%0d_addr: got %0d want %0d", i, addr, td[i]); else n_pass++;
         n_checks++; if (lo !== res[31:0]) $display("FAIL directed%0d_lo: got %h want %h", i, lo, res[31:0]); else n_pass++;
         n_checks++; if (hi !== res[63:32]) $display("FAIL directed%0d_hi: got %h want %h", i, hi, res[63:32]); else n_pass++;
         n_checks++; if (obs_busy != e_busy) $display("FAIL directed%0d_busy: got %0d want %0d", i, obs_busy, e_busy); else n_pass++;
      end
   endtask

   task automatic test_early_out();
      logic [31:0] ta[2] = '{32'h0000_0005, 32'h0000_0000};
      logic [31:0] tb[2] = '{32'h0000_0000, 32'hFFFF_FFF0};
      logic        ts[2] = '{1'b0, 1'b1};
      logic [4:0]  td[2] = '{5'd5, 5'd9};
      int          e_lat, e_pulses, e_busy, lat;
      logic [63:0] res;
      logic [4:0]  addr;
      logic [31:0] lo, hi;
      for (int i = 0; i < 2; i++) begin
         model_op(ta[i], tb[i], ts[i], td[i], e_lat, e_pulses, e_busy, res);
         run_op(ta[i], tb[i], ts[i], td[i], 40, -1, 32'h0, 32'h0, 1'b0, 5'd0);
         first_pulse(0, lat, addr, lo, hi);
         n_checks++; if (obs_cyc.size() != e_pulses) $display("FAIL early%0d_pulses: got %0d want %0d", i, obs_cyc.size(), e_pulses); else n_pass++;
         n_checks++; if (lat != e_lat) $display("FAIL early%0d_latency: got %0d want %0d", i, lat, e_lat); else n_pass++;
         n_checks++; if (addr !== td[i]) $display("FAIL early%0d_addr: got %0d want %0d", i, addr, td[i]); else n_pass++;
         n_checks++; if ({hi, lo} !== res) $display("FAIL early%0d_data: got %h want %h", i, {hi, lo}, res); else n_pass++;
         n_checks++; if (obs_busy != e_busy) $display("FAIL early%0d_busy: got %0d want %0d", i, obs_busy, e_busy); else n_pass++;
      end
   endtask

   task automatic test_dst_zero();
      int          e_lat, e_pulses, e_busy;
      logic [63:0] res;
      model_op(32'h0000_1234, 32'h0000_5678, 1'b0, 5'd0, e_lat, e_pulses, e_busy, res);
      run_op(32'h0000_1234, 32'h0000_5678, 1'b0, 5'd0, 40, -1, 32'h0, 32'h0, 1'b0, 5'd0);
      n_checks++; if (obs_cyc.size() != e_pulses) $display("FAIL dst0_pulses: got %0d want %0d", obs_cyc.size(), e_pulses); else n_pass++;
      n_checks++; if (obs_busy != e_busy) $display("FAIL dst0_busy: got %0d want %0d", obs_busy, e_busy); else n_pass++;
      n_checks++; if (bus.wrAddr !== m_addr) $display("FAIL dst0_hold_addr: got %0d want %0d", bus.wrAddr, m_addr); else n_pass++;
      n_checks++; if (bus.wrData !== m_lo) $display("FAIL dst0_hold_lo: got %h want %h", bus.wrData, m_lo); else n_pass++;
      n_checks++; if (bus.wrDataExt !== m_hi) $display("FAIL dst0_hold_hi: got %h want %h", bus.wrDataExt, m_hi); else n_pass++;
   endtask

   task automatic test_ignored_start();
      int          e_lat, e_pulses, e_busy, lat;
      logic [63:0] res;
      logic [4:0]  addr;
      logic [31:0] lo, hi;
      model_op(32'h0001_0001, 32'h0000_00FF, 1'b0, 5'd21, e_lat, e_pulses, e_busy, res);
      run_op(32'h0001_0001, 32'h0000_00FF, 1'b0, 5'd21, 40, 5, 32'h0000_0007, 32'h0000_0009, 1'b0, 5'd4);
      first_pulse(0, lat, addr, lo, hi);
      n_checks++; if (obs_cyc.size() != 1) $display("FAIL ignored_pulses: got %0d want 1", obs_cyc.size()); else n_pass++;
      n_checks++; if (lat != e_lat) $display("FAIL ignored_latency: got %0d want %0d", lat, e_lat); else n_pass++;
      n_checks++; if (addr !== 5'd21) $display("FAIL ignored_addr: got %0d want 21", addr); else n_pass++;
      n_checks++; if ({hi, lo} !== res) $display("FAIL ignored_data: got %h want %h", {hi, lo}, res); else n_pass++;
      n_checks++; if (obs_busy != e_busy) $display("FAIL ignored_busy: got %0d want %0d", obs_busy, e_busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int          l1, p1, b1, l2, p2, b2, lat;
      logic [63:0] r1, r2;
      logic [4:0]  addr;
      logic [31:0] lo, hi;
      model_op(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 5'd2, l1, p1, b1, r1);
      model_op(32'hFFFF_FF00, 32'h0123_4567, 1'b1, 5'd6, l2, p2, b2, r2);
      // Edge 33 leaves WB, so edge 34 is the first one sampling start in IDLE.
      run_op(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 5'd2, 70, 34, 32'hFFFF_FF00, 32'h0123_4567, 1'b1, 5'd6);
      n_checks++; if (obs_cyc.size() != p1 + p2) $display("FAIL b2b_pulses: got %0d want %0d", obs_cyc.size(), p1 + p2); else n_pass++;
      n_checks++; if (obs_busy != b1 + b2) $display("FAIL b2b_busy: got %0d want %0d", obs_busy, b1 + b2); else n_pass++;
      first_pulse(0, lat, addr, lo, hi);
      n_checks++; if ({hi, lo} !== r1) $display("FAIL b2b_first_data: got %h want %h", {hi, lo}, r1); else n_pass++;
      first_pulse(1, lat, addr, lo, hi);
      n_checks++; if (lat != 34 + l2) $display("FAIL b2b_second_latency: got %0d want %0d", lat, 34 + l2); else n_pass++;
      n_checks++; if (addr !== 5'd6) $display("FAIL b2b_second_addr: got %0d want 6", addr); else n_pass++;
      n_checks++; if ({hi, lo} !== r2) $display("FAIL b2b_second_data: got %h want %h", {hi, lo}, r2); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int rw_seen = 0;
      int busy_seen = 0;
      run_op(32'h0001_2345, 32'h0000_0777, 1'b0, 5'd14, 10, -1, 32'h0, 32'h0, 1'b0, 5'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else n_pass++;
      n_checks++; if (bus.RegWrite !== 1'b0) $display("FAIL abort_regwrite: got %b want 0", bus.RegWrite); else n_pass++;
      n_checks++; if (bus.wrAddr !== 5'd0) $display("FAIL abort_wraddr: got %0d want 0", bus.wrAddr); else n_pass++;
      n_checks++; if (bus.wrData !== 32'h0) $display("FAIL abort_wrdata: got %h want 0", bus.wrData); else n_pass++;
      n_checks++; if (bus.wrDataExt !== 32'h0) $display("FAIL abort_wrdataext: got %h want 0", bus.wrDataExt); else n_pass++;
      @(negedge clk);
      reset  = 1'b0;
      m_addr = 5'd0;
      m_lo   = 32'h0;
      m_hi   = 32'h0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.RegWrite === 1'b1) rw_seen++;
         if (bus.busy === 1'b1) busy_seen++;
      end
      n_checks++; if (rw_seen != 0) $display("FAIL abort_no_strobe: got %0d strobes want 0", rw_seen); else n_pass++;
      n_checks++; if (busy_seen != 0) $display("FAIL abort_stays_idle: got %0d busy cycles want 0", busy_seen); else n_pass++;
   endtask

   task automatic test_random();
      int          e_lat, e_pulses, e_busy, lat;
      logic [63:0] res;
      logic [4:0]  addr, dst;
      logic [31:0] lo, hi, a, b;
      logic        sgn;
      for (int i = 0; i < 10; i++) begin
         a   = $urandom;
         b   = $urandom;
         if ($urandom_range(0, 4) == 0) b = 32'h0;
         sgn = 1'($urandom_range(0, 1));
         dst = 5'($urandom_range(1, 31));
         model_op(a, b, sgn, dst, e_lat, e_pulses, e_busy, res);
         run_op(a, b, sgn, dst, 40, -1, 32'h0, 32'h0, 1'b0, 5'd0);
         first_pulse(0, lat, addr, lo, hi);
         n_checks++; if (obs_cyc.size() != e_pulses) $display("FAIL rand%0d_pulses: got %0d want %0d", i, obs_cyc.size(), e_pulses); else n_pass++;
         n_checks++; if (lat != e_lat) $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, e_lat); else n_pass++;
         n_checks++; if (addr !== dst) $display("FAIL rand%0d_addr: got %0d want %0d", i, addr, dst); else n_pass++;
         n_checks++; if ({hi, lo} !== res) $display("FAIL rand%0d_data: a=%h b=%h s=%b got %h want %h", i, a, b, sgn, {hi, lo}, res); else n_pass++;
         n_checks++; if (obs_busy != e_busy) $display("FAIL rand%0d_busy: got %0d want %0d", i, obs_busy, e_busy); else n_pass++;
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.opA       = 32'h0;
      bus.opB       = 32'h0;
      bus.dstAddr   = 5'd0;
      test_reset();
      test_directed();
      test_early_out();
      test_dst_zero();
      test_ignored_start();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
